slib_fifo_ctrl: RTL and testbench
=================================

SLIB_FIFO_CTRL -- requirements
Module: slib_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter SIZE_E, default 6, meaning log2 of memory entries; pointers are SIZE_E+1 bits.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state on rising edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port CLEAR  input  1  synchronous flush of pointers, count and OVERFLOW.
REQ-006 The block SHALL have port FIFO64  input  1  1 = depth 64, 0 = depth 16.
REQ-007 The block SHALL have port TRIG_LVL  input  2  trigger-level select.
REQ-008 The block SHALL have port WR_REQ  input  1  writer request; held until WR_ACK.
REQ-009 The block SHALL have port D  input  WIDTH  write data, valid with WR_REQ.
REQ-010 The block SHALL have port WR_ACK  output  1  write accepted this cycle.
REQ-011 The block SHALL have port RD_REQ  input  1  reader request; held until RD_ACK.
REQ-012 The block SHALL have port RD_ACK  output  1  read accepted this cycle.
REQ-013 The block SHALL have port RVALID  output  1  memory Q valid (one cycle after RD_ACK).
REQ-014 The block SHALL have memory-side ports MEM_READ, MEM_WRITE (output, 1), MEM_RDADDR, MEM_WRADDR (output, SIZE_E+1) and MEM_D (output, WIDTH).
REQ-015 The block SHALL have port USAGE  output  SIZE_E+1  entries stored.
REQ-016 The block SHALL have flag outputs EMPTY, FULL, TRIG and OVERFLOW (output, 1 each).

Function
REQ-017 The block SHALL perform at most one memory access per cycle: MEM_READ and MEM_WRITE are never both 1.
REQ-018 Eligibility SHALL be: write eligible = WR_REQ & !FULL & !CLEAR; read eligible = RD_REQ & !EMPTY & !CLEAR.
REQ-019 When exactly one request is eligible, that request SHALL be granted.
REQ-020 When both requests are eligible, the grant SHALL go round-robin to the side not granted last.
REQ-021 Acks SHALL be combinational: WR_ACK = MEM_WRITE; RD_ACK = MEM_READ.
REQ-022 MEM_D SHALL equal D; MEM_WRADDR and MEM_RDADDR SHALL be the current write and read pointers.
REQ-023 On a write grant the write pointer SHALL increment by 1 mod 2^(SIZE_E+1); on a read grant the read pointer SHALL increment likewise.
REQ-024 RVALID SHALL be MEM_READ registered by one cycle.
REQ-025 USAGE SHALL equal write pointer minus read pointer, mod 2^(SIZE_E+1).
REQ-026 EMPTY SHALL be (USAGE==0), and FULL SHALL be (USAGE >= depth), with depth = 64 when FIFO64=1 and 16 otherwise.
REQ-027 A change of FIFO64 SHALL take effect immediately and retain stored entries; if USAGE exceeds the new depth, FULL=1 until the FIFO drains below it.
REQ-028 TRIG SHALL be (USAGE >= level), with levels for TRIG_LVL 0..3 of 1/16/32/56 when FIFO64=1 and 1/4/8/14 otherwise.
REQ-029 OVERFLOW SHALL be set when WR_REQ=1 while FULL=1, and SHALL stay sticky until CLEAR or reset; losing arbitration SHALL NOT set it.
REQ-030 CLEAR SHALL have priority over requests: no acks that cycle; next cycle pointers=0, USAGE=0 and OVERFLOW=0.
REQ-031 CLEAR SHALL leave RVALID for an access already issued unaffected, and SHALL leave the round-robin state unchanged.

Reset
REQ-032 While RST_N=0, the block SHALL asynchronously force: both pointers 0, USAGE 0, EMPTY 1, FULL 0, TRIG 0, OVERFLOW 0, RVALID 0, and last-grant = read (the first conflict grants write).
REQ-033 While RST_N=0, MEM_READ, MEM_WRITE, WR_ACK and RD_ACK SHALL be 0 regardless of requests.
REQ-034 Reset release SHALL be usable on the next clock edge; reset mid-transfer SHALL discard the in-flight RVALID.

Structure
REQ-035 Package slib_fifo_pkg SHALL hold the depth constants (16, 64) and the two 4-entry trigger-level tables.
REQ-036 The two-requester round-robin grant logic SHALL be the sub-module slib_rr_arb2 (inputs req[1:0]; outputs gnt[1:0]; holds last-grant state).
REQ-037 Pointer, count and flag logic SHALL live in slib_fifo_ctrl and require no other sub-modules.

Verification
REQ-038 The bench SHALL cover: reset, then 16 writes with FIFO64=0 -> USAGE=16, FULL=1, TRIG=1 at TRIG_LVL=3 from write 14 onward.
REQ-039 The bench SHALL cover: WR_REQ held with FULL=1 -> WR_ACK=0 and OVERFLOW=1 sticky; CLEAR -> USAGE=0, EMPTY=1, OVERFLOW=0.
REQ-040 The bench SHALL cover: WR_REQ and RD_REQ both held with USAGE=5 -> grants alternate W,R,W,R with USAGE oscillating 6/5 and never both MEM strobes high.
REQ-041 The bench SHALL cover: RD_REQ with EMPTY=1 -> no RD_ACK; after one write, RD_ACK next cycle, then RVALID one cycle later with MEM_RDADDR=0.
REQ-042 The bench SHALL cover: 130 write/read pairs with FIFO64=1 -> pointers wrap 127->0, USAGE stays correct and the data order matches.
REQ-043 The bench SHALL cover: USAGE=40 with FIFO64=1, then switch to 0 -> FULL=1; reads clear FULL at USAGE=15; RST_N low mid-read drops RVALID immediately.

Source files
------------

// File: rtl/slib_fifo_pkg.sv
// ============================================================================
// Module      : slib_fifo_pkg
// Description : Depth constants and trigger-level tables for slib_fifo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slib_fifo_pkg;

    localparam int DEPTH_16 = 16;
    localparam int DEPTH_64 = 64;

    localparam int TRIG_TBL_16 [4] = '{1, 4, 8, 14};
    localparam int TRIG_TBL_64 [4] = '{1, 16, 32, 56};

    function automatic int trig_level(input logic fifo64, input logic [1:0] lvl);
        return fifo64 ? TRIG_TBL_64[lvl] : TRIG_TBL_16[lvl];
    endfunction

endpackage

`default_nettype wire

// File: rtl/slib_rr_arb2.sv
// ============================================================================
// Module      : slib_rr_arb2
// Description : Two-requester round-robin arbiter; a conflict goes to the
//               side that did not win the previous grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slib_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when requester 1 won last; reset value makes the first conflict go to 0.
    logic last_gnt1;

    always_comb begin
        gnt[0] = req[0] & (~req[1] | last_gnt1);
        gnt[1] = req[1] & (~req[0] | ~last_gnt1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt1 <= 1'b1;
        end else if (|gnt) begin
            last_gnt1 <= gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/slib_fifo_ctrl.sv
// ============================================================================
// Module      : slib_fifo_ctrl
// Description : FIFO controller for a single-port memory: arbitrates write and
//               read requests, tracks pointers, occupancy and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slib_fifo_ctrl
    import slib_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              fifo64,
    input  logic [1:0]        trig_lvl,
    input  logic              wr_req,
    input  logic [WIDTH-1:0]  d,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic              rvalid,
    output logic              mem_read,
    output logic              mem_write,
    output logic [SIZE_E:0]   mem_rdaddr,
    output logic [SIZE_E:0]   mem_wraddr,
    output logic [WIDTH-1:0]  mem_d,
    output logic [SIZE_E:0]   usage,
    output logic              empty,
    output logic              full,
    output logic              trig,
    output logic              overflow
);

    localparam int PW = SIZE_E + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] depth;
    logic [PW-1:0] level;
    logic [1:0]    req;
    logic [1:0]    gnt;

    // Depth follows fifo64 immediately; stored entries are never discarded.
    always_comb begin
        depth = fifo64 ? PW'(DEPTH_64) : PW'(DEPTH_16);
        level = PW'(trig_level(fifo64, trig_lvl));
        usage = wr_ptr - rd_ptr;
        empty = (usage == '0);
        full  = (usage >= depth);
        trig  = (usage >= level);
    end

    // Gating with rst_n keeps the memory strobes quiet while reset is held.
    always_comb begin
        req[0] = rst_n & wr_req & ~full  & ~clear;
        req[1] = rst_n & rd_req & ~empty & ~clear;
    end

    slib_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    always_comb begin
        mem_write  = gnt[0];
        mem_read   = gnt[1];
        wr_ack     = mem_write;
        rd_ack     = mem_read;
        mem_d      = d;
        mem_wraddr = wr_ptr;
        mem_rdaddr = rd_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (mem_write) wr_ptr <= wr_ptr + 1'b1;
            if (mem_read)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_req && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rvalid <= 1'b0;
        else        rvalid <= mem_read;
    end

endmodule

`default_nettype wire

// File: tb/tb_slib_fifo_ctrl.sv
// ============================================================================
// Module      : tb_slib_fifo_ctrl
// Description : Directed self-checking bench for slib_fifo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slib_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear, fifo64, wr_req, rd_req;
    logic [1:0] trig_lvl;
    logic [7:0] d;
    logic       wr_ack, rd_ack, rvalid, mem_read, mem_write;
    logic [6:0] mem_rdaddr, mem_wraddr, usage;
    logic [7:0] mem_d;
    logic       empty, full, trig, overflow;

    logic [7:0] mem [128];
    logic [7:0] q;
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slib_fifo_ctrl #(.WIDTH(8), .SIZE_E(6)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .fifo64(fifo64), .trig_lvl(trig_lvl),
        .wr_req(wr_req), .d(d), .wr_ack(wr_ack), .rd_req(rd_req), .rd_ack(rd_ack),
        .rvalid(rvalid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdaddr(mem_rdaddr), .mem_wraddr(mem_wraddr), .mem_d(mem_d),
        .usage(usage), .empty(empty), .full(full), .trig(trig), .overflow(overflow)
    );

    always @(posedge clk) begin
        if (mem_write) mem[mem_wraddr] <= mem_d;
        if (mem_read)  q <= mem[mem_rdaddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returned data must come back in write order.
    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) check("rdata_unexpected", 32'(exp_q.size()), 1);
            else                   check("rdata", {24'd0, q}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; fifo64 = 1'b0; trig_lvl = 2'd3;
        wr_req = 1'b1; rd_req = 1'b1; d = 8'h00;
        #1;
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_usage", usage, 0);
        check("rst_flags", {empty, full, trig, overflow, rvalid}, 5'b10000);
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 16 writes, depth 16, trigger level 14
        wr_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'(i);
            #1;
            check("fill_wr_ack", wr_ack, 1);
            check("fill_wraddr", mem_wraddr, 32'(i));
            tick();
            check("fill_usage", usage, 32'(i + 1));
            check("fill_trig", trig, (i + 1 >= 14) ? 1 : 0);
        end
        check("fill_full", full, 1);
        check("full_no_ack", wr_ack, 0);
        check("ovf_not_yet", overflow, 0);
        tick();
        check("ovf_set", overflow, 1);
        check("ovf_usage", usage, 16);
        wr_req = 1'b0;
        tick();
        check("ovf_sticky", overflow, 1);
        clear = 1'b1; wr_req = 1'b1;
        #1;
        check("clear_no_ack", wr_ack, 0);
        tick();
        clear = 1'b0; wr_req = 1'b0;
        #1;
        check("clear_usage", usage, 0);
        check("clear_flags", {empty, full, overflow}, 3'b100);

        // read while empty, then one write followed by its read
        rd_req = 1'b1;
        #1;
        check("empty_no_rdack", rd_ack, 0);
        tick();
        check("empty_no_rvalid", rvalid, 0);
        wr_req = 1'b1; d = 8'hA5; exp_q.push_back(8'hA5);
        #1;
        check("one_wr_ack", wr_ack, 1);
        check("one_rd_blocked", rd_ack, 0);
        tick();
        wr_req = 1'b0;
        #1;
        check("one_rd_ack", rd_ack, 1);
        check("one_rdaddr", mem_rdaddr, 0);
        tick();
        rd_req = 1'b0;
        check("one_rvalid", rvalid, 1);
        tick();

        // bring usage to 5 with a read granted last, then contend
        wr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'h10 + i); exp_q.push_back(d);
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("rr_start_usage", usage, 5);
        wr_req = 1'b1; rd_req = 1'b1;
        for (int j = 0; j < 4; j++) begin
            d = 8'(8'h20 + j);
            if (j % 2 == 0) exp_q.push_back(d);
            #1;
            check("rr_write", mem_write, (j % 2 == 0) ? 1 : 0);
            check("rr_read", mem_read, (j % 2 == 1) ? 1 : 0);
            check("rr_not_both", mem_write & mem_read, 0);
            tick();
            check("rr_usage", usage, (j % 2 == 0) ? 6 : 5);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        exp_q.delete();

        // 130 write/read pairs at depth 64: pointers wrap past 127
        fifo64 = 1'b1;
        for (int i = 0; i < 130; i++) begin
            wr_req = 1'b1; d = 8'(i * 3 + 1); exp_q.push_back(d);
            #1;
            check("wrap_wr_ack", wr_ack, 1);
            check("wrap_wraddr", mem_wraddr, 32'(i % 128));
            tick();
            wr_req = 1'b0; rd_req = 1'b1;
            #1;
            check("wrap_usage1", usage, 1);
            check("wrap_rdaddr", mem_rdaddr, 32'(i % 128));
            tick();
            rd_req = 1'b0;
            check("wrap_usage0", usage, 0);
        end
        check("wrap_final_wraddr", mem_wraddr, 2);

        // 40 entries at depth 64, then shrink to 16 and drain
        trig_lvl = 2'd2;
        wr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = 8'(8'h40 + i); exp_q.push_back(d);
            tick();
            check("big_trig", trig, (i + 1 >= 32) ? 1 : 0);
        end
        wr_req = 1'b0;
        #1;
        check("big_usage", usage, 40);
        check("big_not_full", full, 0);
        fifo64 = 1'b0;
        #1;
        check("shrink_full", full, 1);
        check("shrink_usage", usage, 40);
        rd_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check("drain_usage", usage, 32'(40 - k));
            check("drain_full", full, (40 - k >= 16) ? 1 : 0);
        end
        check("midread_rvalid", rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_rvalid_drop", rvalid, 0);
        check("rst_usage2", usage, 0);
        check("rst_empty2", empty, 1);
        check("rst_mem_read2", mem_read, 0);
        exp_q.delete();
        rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        wr_req = 1'b1; d = 8'h77; exp_q.push_back(d);
        #1;
        check("post_rst_wr_ack", wr_ack, 1);
        tick();
        wr_req = 1'b0;
        check("post_rst_usage", usage, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
